// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM states, frame configuration
// and the legal oversampling ratios.
package uart_pkg;

    localparam logic [5:0] PRESCALE_X8  = 6'd8;
    localparam logic [5:0] PRESCALE_X16 = 6'd16;
    localparam logic [5:0] PRESCALE_X32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Frame settings captured once per frame so mid-frame input changes are ignored.
    typedef struct packed {
        logic [5:0] prescale;
        logic       par_en;
        logic       par_typ;
    } uart_cfg_t;

    function automatic logic is_legal_prescale(input logic [5:0] prescale);
        return (prescale == PRESCALE_X8) || (prescale == PRESCALE_X16) ||
               (prescale == PRESCALE_X32);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Bit-period timing for the UART receiver: edge/bit counters and a 2-of-3
// majority vote taken around the middle of each bit.
module uart_rx_sampler #(
    parameter int BW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    input  logic          bit_clr,
    input  logic          rx,
    input  logic [5:0]    prescale,
    output logic [BW-1:0] bit_cnt,
    output logic          bit_done,
    output logic          sample
);

    logic [4:0] edge_cnt;
    logic [5:0] edge_ext;
    logic [5:0] half;
    logic [2:0] votes;

    assign edge_ext = {1'b0, edge_cnt};
    assign half     = prescale >> 1;
    assign bit_done = run && (edge_ext == prescale - 6'd1);
    assign sample   = (votes[0] & votes[1]) | (votes[0] & votes[2]) | (votes[1] & votes[2]);

    // NOTE: every register here is sequential state, so all updates are
    // non-blocking; blocking assignments would race with the FSM reading them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
            votes    <= '0;
        end else begin
            if (!run || bit_done) begin
                edge_cnt <= '0;
            end else begin
                edge_cnt <= edge_cnt + 5'd1;
            end

            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (bit_done) begin
                bit_cnt <= bit_cnt + BW'(1);
            end

            if (run) begin
                if (edge_ext == half - 6'd1) votes[0] <= rx;
                if (edge_ext == half)        votes[1] <= rx;
                if (edge_ext == half + 6'd1) votes[2] <= rx;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop framing FSM with parity and stop
// checking; bit timing and majority sampling live in uart_rx_sampler.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BW = $clog2(DATA_WIDTH + 1);

    rx_state_t             state;
    uart_cfg_t             cfg_q;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  frame_err;
    logic                  run;
    logic                  bit_clr;
    logic                  bit_done;
    logic                  sample;
    logic [BW-1:0]         bit_cnt;
    logic                  last_data_bit;
    logic                  exp_parity;

    assign run           = (state != IDLE);
    assign bit_clr       = (state != DATA);
    assign last_data_bit = (bit_cnt == BW'(DATA_WIDTH - 1));
    assign exp_parity    = (^shift_reg) ^ cfg_q.par_typ;

    uart_rx_sampler #(
        .BW(BW)
    ) u_sampler (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .bit_clr  (bit_clr),
        .rx       (RX_IN),
        .prescale (cfg_q.prescale),
        .bit_cnt  (bit_cnt),
        .bit_done (bit_done),
        .sample   (sample)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cfg_q        <= '{prescale: PRESCALE_X16, par_en: 1'b0, par_typ: 1'b0};
            shift_reg    <= '0;
            frame_err    <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            case (state)
                IDLE: begin
                    if (!RX_IN) begin
                        state     <= START;
                        cfg_q     <= '{prescale: Prescale, par_en: PAR_EN, par_typ: PAR_TYP};
                        frame_err <= 1'b0;
                    end
                end

                START: begin
                    if (bit_done) begin
                        // A high start sample means the falling edge was a glitch.
                        state <= sample ? IDLE : DATA;
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        shift_reg <= {sample, shift_reg[DATA_WIDTH-1:1]};
                        if (last_data_bit) begin
                            state <= cfg_q.par_en ? PARITY : STOP;
                        end
                    end
                end

                PARITY: begin
                    if (bit_done) begin
                        if (sample != exp_parity) begin
                            parity_error <= 1'b1;
                            frame_err    <= 1'b1;
                        end
                        state <= STOP;
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        if (!sample) begin
                            stop_error <= 1'b1;
                        end else if (!frame_err) begin
                            P_DATA     <= shift_reg;
                            data_valid <= 1'b1;
                        end
                        // Line already low at the end of stop: next start bit, back to back.
                        if (!RX_IN) begin
                            state     <= START;
                            cfg_q     <= '{prescale: Prescale, par_en: PAR_EN, par_typ: PAR_TYP};
                            frame_err <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected pulses
// queued per frame and matched against DUT pulses as they appear.
module tb_uart_rx;

    typedef struct {
        logic [2:0] flags;  // {data_valid, parity_error, stop_error}
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic       clk;
    logic       rst_n;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    int         cyc;
    int         checks;
    int         errors;
    int         dv_prev;
    int         dv_last;
    logic [7:0] last_good;
    ev_t        exp_q[$];

    uart_rx #(
        .DATA_WIDTH(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .RX_IN        (RX_IN),
        .Prescale     (Prescale),
        .PAR_EN       (PAR_EN),
        .PAR_TYP      (PAR_TYP),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge and score any output pulse seen there.
    task automatic tick();
        ev_t e;
        @(negedge clk);
        if (data_valid || parity_error || stop_error) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'({data_valid, parity_error, stop_error}), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'({data_valid, parity_error, stop_error}), 32'(e.flags));
                check("p_data", 32'(P_DATA), 32'(e.data));
                check("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (data_valid) begin
                    dv_prev = dv_last;
                    dv_last = cyc;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) tick();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    // Drives one frame; leaves RX_IN at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] data, input int p, input bit par_en,
                              input bit par_odd, input bit bad_par, input bit bad_stop,
                              input bit meddle);
        ev_t  e;
        int   start;
        int   nbits;
        logic par;
        Prescale = 6'(p);
        PAR_EN   = par_en;
        PAR_TYP  = par_odd;
        par      = (^data) ^ par_odd ^ bad_par;
        nbits    = par_en ? 11 : 10;
        start    = cyc + 1;
        if (par_en && bad_par) begin
            e = '{flags: 3'b010, data: last_good, cyc: start + 10 * p};
        end else if (bad_stop) begin
            e = '{flags: 3'b001, data: last_good, cyc: start + nbits * p};
        end else begin
            e = '{flags: 3'b100, data: data, cyc: start + nbits * p};
            last_good = data;
        end
        exp_q.push_back(e);

        RX_IN = 1'b0;
        for (int i = 0; i < p; i++) begin
            tick();
            if (i == 0 && meddle) begin
                Prescale = (p == 16) ? 6'd8 : 6'd16;
                PAR_EN   = ~par_en;
                PAR_TYP  = ~par_odd;
            end
        end
        for (int b = 0; b < 8; b++) begin
            RX_IN = data[b];
            repeat (p) tick();
        end
        if (par_en) begin
            RX_IN = par;
            repeat (p) tick();
        end
        RX_IN = ~bad_stop;
        repeat (p) tick();
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        dv_prev   = 0;
        dv_last   = 0;
        last_good = 8'h00;
        rst_n     = 1'b0;
        RX_IN     = 1'b1;
        Prescale  = 6'd8;
        PAR_EN    = 1'b0;
        PAR_TYP   = 1'b0;

        repeat (3) tick();
        check("reset_p_data", 32'(P_DATA), 32'h0);
        check("reset_data_valid", 32'(data_valid), 32'h0);
        check("reset_parity_error", 32'(parity_error), 32'h0);
        check("reset_stop_error", 32'(stop_error), 32'h0);
        rst_n = 1'b1;
        idle(2);

        // Prescale 8, no parity: 0xA5 lands 80 clk after the start edge.
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        drain(16);
        check("a5_held", 32'(P_DATA), 32'hA5);

        // Prescale 16, even parity, good then bad parity bit.
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        drain(32);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(40);
        drain(32);

        // Prescale 32, odd parity, stop bit low: stop_error, P_DATA keeps 0x3C.
        send_frame(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(70);
        drain(64);
        check("stop_err_p_data_kept", 32'(P_DATA), 32'h3C);

        // 3-clk glitch on idle line, then a normal frame proves the FSM is back in IDLE.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (3) tick();
        idle(40);
        check("glitch_no_pending", 32'(exp_q.size()), 32'd0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        drain(16);

        // Config inputs change right after the frame starts; the frame must ignore it.
        send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(40);
        drain(32);

        // Back-to-back 0x55 / 0xAA at Prescale 16: pulses 160 clk apart.
        send_frame(8'h55, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'hAA, 16, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        drain(32);
        check("b2b_spacing", 32'(dv_last - dv_prev), 32'd160);
        check("b2b_p_data", 32'(P_DATA), 32'hAA);

        // Reset in the middle of the data bits aborts the frame silently.
        Prescale = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        repeat (16) tick();
        RX_IN = 1'b1;
        repeat (16) tick();
        RX_IN = 1'b0;
        repeat (24) tick();
        rst_n = 1'b0;
        RX_IN = 1'b1;
        last_good = 8'h00;
        repeat (2) tick();
        check("rst_mid_p_data", 32'(P_DATA), 32'h0);
        check("rst_mid_flags", 32'({data_valid, parity_error, stop_error}), 32'h0);
        rst_n = 1'b1;
        send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(40);
        drain(16);
        check("after_rst_p_data", 32'(P_DATA), 32'h0F);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
